// File: rtl/macs_seq_ctrl.sv
// -----------------------------------------------------------------------------
// macs_seq_ctrl
// Job sequencer for the 4-lane Macs array.
//   matmul : OUT[i][jb] = C[i][jb] +/- sum_k A[i][k] * B[k][jb]  (4 lanes per jb)
//   matadd : OUT[i][jb] = B[i][jb] + C[i][jb]
// Walks the i (outer) / jb (inner) element loop and the k loop inside each
// element. It fetches operands from the A/B/C memories, issues them to Macs, and
// writes each 4-lane result to the output memory. One job runs per start pulse.
//
// Optional feature: define MACS_SEQ_CTRL_PERF_EN to add the perf_cycles and
// perf_stall counters and their output ports.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start                 job start pulse; ignored while busy
//   cfg_mode/cfg_sub      0=matmul 1=matadd / negate A*B; latched at start
//   cfg_rows/cfg_k/cfg_cb job dimensions; latched at start
//   busy, done            job in progress / 1-cycle end-of-job pulse
//   a_*/b_*/c_*           memory read strobe, address, data (valid 1 cycle later)
//   mac_*                 Macs issue interface and result return
//   out_*                 result write port; accepted on out_we & out_ready
//   perf_cycles/stall     busy cycles / WR cycles stalled (PERF_EN only)
// -----------------------------------------------------------------------------
module macs_seq_ctrl #(
  parameter int DIM_W  = 4,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cfg_mode,
  input  logic              cfg_sub,
  input  logic [DIM_W-1:0]  cfg_rows,
  input  logic [DIM_W-1:0]  cfg_k,
  input  logic [DIM_W-1:0]  cfg_cb,
  output logic              busy,
  output logic              done,
  output logic              a_rd,
  output logic [ADDR_W-1:0] a_addr,
  input  logic [15:0]       a_rdata,
  output logic              b_rd,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [63:0]       b_rdata,
  output logic              c_rd,
  output logic [ADDR_W-1:0] c_addr,
  input  logic [63:0]       c_rdata,
  output logic              mac_en,
  output logic              mac_mode,
  output logic              mac_signal,
  output logic [15:0]       mac_a,
  output logic [63:0]       mac_b,
  output logic [63:0]       mac_c,
  input  logic              mac_valid,
  input  logic [63:0]       mac_result,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [63:0]       out_wdata,
  input  logic              out_ready
`ifdef MACS_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stall
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDC  = 3'd1,
    S_WC   = 3'd2,
    S_RD   = 3'd3,
    S_ISS  = 3'd4,
    S_WM   = 3'd5,
    S_WR   = 3'd6,
    S_DONE = 3'd7
  } state_e;

  function automatic logic [ADDR_W-1:0] zext(input logic [DIM_W-1:0] v);
    return {{(ADDR_W-DIM_W){1'b0}}, v};
  endfunction

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic               sub_q, sub_d;
  logic [DIM_W-1:0]   rows_q, rows_d;
  logic [DIM_W-1:0]   kdim_q, kdim_d;     // effective K (1 in matadd)
  logic [DIM_W-1:0]   cb_q, cb_d;
  logic [DIM_W-1:0]   i_q, i_d;
  logic [DIM_W-1:0]   jb_q, jb_d;
  logic [DIM_W-1:0]   kk_q, kk_d;
  logic [ADDR_W-1:0]  a_row_q, a_row_d;   // i*K, stepped by K per row
  logic [ADDR_W-1:0]  b_k_q, b_k_d;       // k*cb, stepped by cb per k
  logic [ADDR_W-1:0]  out_idx_q, out_idx_d; // i*cb+jb, sequential in loop order
  logic [63:0]        acc_q, acc_d;

  // Registered strobes and addresses, loaded from next-state so they line up
  // with the state they belong to.
  logic               busy_q, done_q, a_rd_q, b_rd_q, c_rd_q, mac_en_q, out_we_q;
  logic [ADDR_W-1:0]  a_addr_q, b_addr_q;

  logic               empty_s;
  logic               last_k_s;
  logic               last_jb_s;
  logic               last_i_s;

  assign empty_s   = (cfg_rows == {DIM_W{1'b0}}) || (cfg_cb == {DIM_W{1'b0}}) ||
                     (!cfg_mode && (cfg_k == {DIM_W{1'b0}}));
  assign last_k_s  = (kk_q == (kdim_q - DIM_W'(1)));
  assign last_jb_s = (jb_q == (cb_q - DIM_W'(1)));
  assign last_i_s  = (i_q == (rows_q - DIM_W'(1)));

  // Next-state, counter and accumulator logic.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    sub_d     = sub_q;
    rows_d    = rows_q;
    kdim_d    = kdim_q;
    cb_d      = cb_q;
    i_d       = i_q;
    jb_d      = jb_q;
    kk_d      = kk_q;
    a_row_d   = a_row_q;
    b_k_d     = b_k_q;
    out_idx_d = out_idx_q;
    acc_d     = acc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d    = cfg_mode;
          sub_d     = cfg_sub;
          rows_d    = cfg_rows;
          kdim_d    = cfg_mode ? DIM_W'(1) : cfg_k;
          cb_d      = cfg_cb;
          i_d       = {DIM_W{1'b0}};
          jb_d      = {DIM_W{1'b0}};
          kk_d      = {DIM_W{1'b0}};
          a_row_d   = {ADDR_W{1'b0}};
          b_k_d     = {ADDR_W{1'b0}};
          out_idx_d = {ADDR_W{1'b0}};
          if (empty_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LDC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LDC: state_d = S_WC;
      S_WC: begin
        acc_d   = c_rdata;
        state_d = S_RD;
      end
      S_RD:  state_d = S_ISS;
      S_ISS: state_d = S_WM;
      S_WM: begin
        if (mac_valid) begin
          acc_d = mac_result;
          if (!last_k_s) begin
            kk_d    = kk_q + DIM_W'(1);
            b_k_d   = b_k_q + zext(cb_q);
            state_d = S_RD;
          end else begin
            state_d = S_WR;
          end
        end else begin
          state_d = S_WM;
        end
      end
      S_WR: begin
        if (out_ready) begin
          kk_d      = {DIM_W{1'b0}};
          b_k_d     = {ADDR_W{1'b0}};
          out_idx_d = out_idx_q + ADDR_W'(1);
          if (last_jb_s) begin
            jb_d = {DIM_W{1'b0}};
            if (last_i_s) begin
              state_d = S_DONE;
            end else begin
              i_d     = i_q + DIM_W'(1);
              a_row_d = a_row_q + zext(kdim_q);
              state_d = S_LDC;
            end
          end else begin
            jb_d    = jb_q + DIM_W'(1);
            state_d = S_LDC;
          end
        end else begin
          state_d = S_WR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, configuration, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      sub_q     <= 1'b0;
      rows_q    <= {DIM_W{1'b0}};
      kdim_q    <= {DIM_W{1'b0}};
      cb_q      <= {DIM_W{1'b0}};
      i_q       <= {DIM_W{1'b0}};
      jb_q      <= {DIM_W{1'b0}};
      kk_q      <= {DIM_W{1'b0}};
      a_row_q   <= {ADDR_W{1'b0}};
      b_k_q     <= {ADDR_W{1'b0}};
      out_idx_q <= {ADDR_W{1'b0}};
      acc_q     <= 64'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      a_rd_q    <= 1'b0;
      b_rd_q    <= 1'b0;
      c_rd_q    <= 1'b0;
      mac_en_q  <= 1'b0;
      out_we_q  <= 1'b0;
      a_addr_q  <= {ADDR_W{1'b0}};
      b_addr_q  <= {ADDR_W{1'b0}};
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      sub_q     <= sub_d;
      rows_q    <= rows_d;
      kdim_q    <= kdim_d;
      cb_q      <= cb_d;
      i_q       <= i_d;
      jb_q      <= jb_d;
      kk_q      <= kk_d;
      a_row_q   <= a_row_d;
      b_k_q     <= b_k_d;
      out_idx_q <= out_idx_d;
      acc_q     <= acc_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      a_rd_q    <= (state_d == S_RD) && !mode_d;
      b_rd_q    <= (state_d == S_RD);
      c_rd_q    <= (state_d == S_LDC);
      mac_en_q  <= (state_d == S_ISS);
      out_we_q  <= (state_d == S_WR);
      a_addr_q  <= a_row_d + zext(kk_d);
      // matadd reads B at the element index; matmul walks B down column block jb
      b_addr_q  <= mode_d ? out_idx_d : (b_k_d + zext(jb_d));
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign a_rd       = a_rd_q;
  assign a_addr     = a_addr_q;
  assign b_rd       = b_rd_q;
  assign b_addr     = b_addr_q;
  assign c_rd       = c_rd_q;
  assign c_addr     = out_idx_q;
  assign mac_en     = mac_en_q;
  assign mac_mode   = mode_q;
  assign mac_signal = sub_q;
  // Read data arrives in the ISS cycle itself, so A/B pass straight through;
  // gating keeps them at 0 outside the issue cycle.
  assign mac_a      = mac_en_q ? a_rdata : 16'd0;
  assign mac_b      = mac_en_q ? b_rdata : 64'd0;
  assign mac_c      = acc_q;
  assign out_we     = out_we_q;
  assign out_addr   = out_idx_q;
  assign out_wdata  = acc_q;

`ifdef MACS_SEQ_CTRL_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_stall_q;

  // Saturating busy-cycle and write-stall counters, cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q <= 32'd0;
      perf_stall_q  <= 32'd0;
    end else if ((state_q == S_IDLE) && start) begin
      perf_cycles_q <= 32'd0;
      perf_stall_q  <= 32'd0;
    end else begin
      if (busy_q && (perf_cycles_q != 32'hFFFF_FFFF)) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end else begin
        perf_cycles_q <= perf_cycles_q;
      end
      if ((state_q == S_WR) && !out_ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end else begin
        perf_stall_q <= perf_stall_q;
      end
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule
